// File: rtl/iob_iob2wishbone_pkg.sv
// ----------------------------------------------------------------------------
// iob_iob2wishbone_pkg
//   Shared definitions for the IOb-to-Wishbone bridge: the 2-bit FSM state
//   type and its encodings. The same encodings are used by the companion
//   Wishbone-to-IOb bridge, so keep them stable.
// ----------------------------------------------------------------------------
package iob_iob2wishbone_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;  // waiting for an IOb request
  localparam state_t ST_BUSY = 2'd1;  // Wishbone cycle in progress
  localparam state_t ST_RESP = 2'd2;  // one-cycle IOb completion

endpackage : iob_iob2wishbone_pkg

// File: rtl/iob_iob2wishbone_timeout.sv
// ----------------------------------------------------------------------------
// iob_iob2wishbone_timeout
//   Watchdog for a Wishbone cycle. The counter is cleared when a transfer is
//   accepted and counts the BUSY cycles already elapsed. expired_o rises in the
//   TIMEOUT_CYCLES-th BUSY cycle, so cyc/stb drop after exactly TIMEOUT_CYCLES
//   cycles. TIMEOUT_CYCLES must be at least 1.
// Ports
//   clk_i      clock
//   arst_n_i   asynchronous active-low reset
//   clear_i    transfer accepted this cycle (BUSY starts next cycle)
//   busy_i     bridge is in BUSY
//   expired_o  BUSY cycle budget used up in this cycle
// ----------------------------------------------------------------------------
module iob_iob2wishbone_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic clear_i,
  input  logic busy_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;
  logic             expired_s;

  // Expiry decode: last allowed BUSY cycle reached.
  always_comb begin
    expired_s = busy_i & (count_r == LAST_C);
  end

  assign expired_o = expired_s;

  // BUSY-cycle counter; holds at the last value so it never wraps.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (busy_i && !expired_s) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule : iob_iob2wishbone_timeout

// File: rtl/iob_iob2wishbone.sv
// ----------------------------------------------------------------------------
// iob_iob2wishbone
//   Bridge from an IOb slave port to a classic (B3) Wishbone master port.
//   One transfer at a time, all outputs registered.
//   Optional feature macro: IOB2WB_TIMEOUT_EN -- aborts a Wishbone cycle that
//   sees no ack/err within TIMEOUT_CYCLES BUSY cycles (ends with error_o=1).
// Ports
//   clk_i, arst_n_i          clock, asynchronous active-low reset
//   valid_i                  IOb request pulse
//   address_i/wdata_i        IOb address / write data
//   wstrb_i                  IOb byte strobes, zero means read
//   rdata_o/ready_o/error_o  IOb response (ready_o pulses once per request)
//   wb_addr_o..wb_data_o     Wishbone master outputs (registered)
//   wb_data_i/wb_ack_i       Wishbone read data / acknowledge
//   wb_error_i               Wishbone error termination
// ----------------------------------------------------------------------------
module iob_iob2wishbone
  import iob_iob2wishbone_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA      = {DATA_W{1'b0}}
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                error_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W/8-1:0] wb_select_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  input  logic                wb_error_i
);

  localparam int unsigned SEL_W = DATA_W / 8;

  state_t              state_r;
  state_t              state_next_s;
  logic                accept_s;
  logic                busy_s;
  logic                done_s;
  logic                fail_s;
  logic                expired_s;
  logic [DATA_W-1:0]   rdata_next_s;

  logic [ADDR_W-1:0]   wb_addr_r;
  logic [SEL_W-1:0]    wb_select_r;
  logic                wb_we_r;
  logic                wb_cyc_r;
  logic [DATA_W-1:0]   wb_data_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                ready_r;
  logic                error_r;

  // FSM decode: a request is accepted in IDLE or RESP only (BUSY ignores valid_i).
  always_comb begin
    accept_s     = 1'b0;
    state_next_s = state_r;
    busy_s       = (state_r == ST_BUSY);
    // ack, err or watchdog expiry ends the cycle; err always wins, ack beats expiry.
    done_s       = busy_s & (wb_ack_i | wb_error_i | expired_s);
    fail_s       = wb_error_i | ~wb_ack_i;
    case (state_r)
      ST_IDLE: begin
        if (valid_i) begin
          accept_s     = 1'b1;
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        if (valid_i) begin
          accept_s     = 1'b1;
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        accept_s     = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Response data selection: error value, zero for writes, slave data for reads.
  always_comb begin
    rdata_next_s = {DATA_W{1'b0}};
    if (fail_s) begin
      rdata_next_s = ERR_RDATA;
    end else if (wb_we_r) begin
      rdata_next_s = {DATA_W{1'b0}};
    end else begin
      rdata_next_s = wb_data_i;
    end
  end

`ifdef IOB2WB_TIMEOUT_EN
  iob_iob2wishbone_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .clear_i   (accept_s),
    .busy_i    (busy_s),
    .expired_o (expired_s)
  );
`else
  // Without the watchdog BUSY waits for ack/err indefinitely.
  logic [31:0] timeout_cycles_unused_s;
  assign timeout_cycles_unused_s = 32'(TIMEOUT_CYCLES);
  assign expired_s               = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wishbone request registers: loaded on accept, stable for the whole cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wb_addr_r   <= {ADDR_W{1'b0}};
      wb_select_r <= {SEL_W{1'b0}};
      wb_we_r     <= 1'b0;
      wb_data_r   <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      wb_addr_r   <= address_i;
      wb_select_r <= (|wstrb_i) ? wstrb_i : {SEL_W{1'b1}};
      wb_we_r     <= |wstrb_i;
      wb_data_r   <= wdata_i;
    end
  end

  // cyc/stb: raised on accept, dropped on the edge after termination.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wb_cyc_r <= 1'b0;
    end else if (accept_s) begin
      wb_cyc_r <= 1'b1;
    end else if (done_s) begin
      wb_cyc_r <= 1'b0;
    end
  end

  // IOb response registers; rdata holds until the next completion.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rdata_r <= {DATA_W{1'b0}};
      ready_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      ready_r <= done_s;
      error_r <= done_s & fail_s;
      if (done_s) begin
        rdata_r <= rdata_next_s;
      end
    end
  end

  assign wb_addr_o   = wb_addr_r;
  assign wb_select_o = wb_select_r;
  assign wb_we_o     = wb_we_r;
  assign wb_cyc_o    = wb_cyc_r;
  assign wb_stb_o    = wb_cyc_r;
  assign wb_data_o   = wb_data_r;
  assign rdata_o     = rdata_r;
  assign ready_o     = ready_r;
  assign error_o     = error_r;

endmodule : iob_iob2wishbone

// File: tb/tb_iob_iob2wishbone.sv
// ----------------------------------------------------------------------------
// tb_iob_iob2wishbone
//   Randomised plus directed bench for the IOb-to-Wishbone bridge. Stimulus
//   pushes the expected Wishbone request and the expected IOb response into
//   queues; a monitor on the falling edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_iob_iob2wishbone;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;
  localparam int TO_CYC = 8;
  localparam logic [DATA_W-1:0] ERR_RD = 32'hBAD0_BAD0;

  logic              clk;
  logic              rst_n;
  logic              valid_i;
  logic [ADDR_W-1:0] address_i;
  logic [DATA_W-1:0] wdata_i;
  logic [SEL_W-1:0]  wstrb_i;
  logic [DATA_W-1:0] rdata_o;
  logic              ready_o;
  logic              error_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [SEL_W-1:0]  wb_select_o;
  logic              wb_we_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [DATA_W-1:0] wb_data_i;
  logic              wb_ack_i;
  logic              wb_error_i;

  iob_iob2wishbone #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO_CYC),
    .ERR_RDATA      (ERR_RD)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (rst_n),
    .valid_i     (valid_i),
    .address_i   (address_i),
    .wdata_i     (wdata_i),
    .wstrb_i     (wstrb_i),
    .rdata_o     (rdata_o),
    .ready_o     (ready_o),
    .error_o     (error_o),
    .wb_addr_o   (wb_addr_o),
    .wb_select_o (wb_select_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_data_o   (wb_data_o),
    .wb_data_i   (wb_data_i),
    .wb_ack_i    (wb_ack_i),
    .wb_error_i  (wb_error_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                cyc;
  } rsp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic              we;
    logic [DATA_W-1:0] data;
    int                cyc;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  req_t cur_req;
  logic prev_cyc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: compares IOb responses and Wishbone requests against the queues.
  always @(negedge clk) begin
    rsp_t e;
    if (ready_o) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready_o=1 expected 0 (cycle %0d)", cyc_cnt);
      end else begin
        e = rsp_q.pop_front();
        check("rdata", 64'(rdata_o), 64'(e.rdata));
        check("error", 64'(error_o), 64'(e.err));
        check("ready_cycle", 64'(cyc_cnt), 64'(e.cyc));
      end
    end else if (error_o) begin
      total++;
      bad++;
      $display("FAIL lone_error: got error_o=1 expected 0 without ready_o (cycle %0d)", cyc_cnt);
    end
    if (wb_cyc_o && !prev_cyc) begin
      if (req_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cyc: got wb_cyc_o=1 expected 0 (cycle %0d)", cyc_cnt);
      end else begin
        cur_req = req_q.pop_front();
        check("wb_cyc_cycle", 64'(cyc_cnt), 64'(cur_req.cyc));
      end
    end
    if (wb_cyc_o) begin
      check("wb_stb", 64'(wb_stb_o), 64'd1);
      check("wb_addr", 64'(wb_addr_o), 64'(cur_req.addr));
      check("wb_ctl", 64'({wb_we_o, wb_select_o}), 64'({cur_req.we, cur_req.sel}));
      check("wb_data", 64'(wb_data_o), 64'(cur_req.data));
    end
    prev_cyc <= wb_cyc_o;
  end

  // Drive one IOb request; returns #1 into the first BUSY cycle.
  task automatic start_req(input bit now, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s,
                           output int t0);
    req_t r;
    if (!now) begin
      @(posedge clk); #1;
    end
    valid_i = 1'b1; address_i = a; wdata_i = d; wstrb_i = s;
    t0 = cyc_cnt;
    r.addr = a;
    r.sel  = (s == 0) ? {SEL_W{1'b1}} : s;
    r.we   = (s != 0);
    r.data = d;
    r.cyc  = t0 + 1;
    req_q.push_back(r);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Full transfer: slave terminates after 'delay' extra BUSY cycles.
  // Returns #1 into the RESP cycle so a back-to-back request can follow.
  task automatic do_xfer(input bit now, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s,
                         input int delay, input logic [DATA_W-1:0] rd,
                         input bit err, input bit ack, input bit spur);
    int   t0;
    rsp_t e;
    start_req(now, a, d, s, t0);
    e.err   = err;
    e.rdata = err ? ERR_RD : ((s == 0) ? rd : {DATA_W{1'b0}});
    e.cyc   = t0 + delay + 2;
    rsp_q.push_back(e);
    if (spur) begin
      valid_i = 1'b1; address_i = ~a; wdata_i = ~d; wstrb_i = ~s;
    end
    repeat (delay) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    wb_ack_i = ack; wb_error_i = err; wb_data_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0; wb_ack_i = 1'b0; wb_error_i = 1'b0; wb_data_i = $urandom;
  endtask

  // Stray termination while IDLE must be ignored.
  task automatic idle_noise();
    @(posedge clk); #1;
    wb_ack_i = 1'b1; wb_error_i = 1'($urandom_range(0, 1)); wb_data_i = $urandom;
    @(posedge clk); #1;
    wb_ack_i = 1'b0; wb_error_i = 1'b0;
  endtask

  // Assert reset between edges; all outputs must clear at once.
  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    check("rst_rdata", 64'(rdata_o), 64'd0);
    check("rst_wb_addr", 64'(wb_addr_o), 64'd0);
    check("rst_wb_data", 64'(wb_data_o), 64'd0);
    check("rst_ctl", 64'({ready_o, error_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_select_o}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  t0;
    bit  b2b;
    logic [SEL_W-1:0] s;
    rst_n = 1'b0; valid_i = 1'b0; address_i = '0; wdata_i = '0; wstrb_i = '0;
    wb_data_i = '0; wb_ack_i = 1'b0; wb_error_i = 1'b0;
    #12;
    check("reset_rdata", 64'(rdata_o), 64'd0);
    check("reset_ctl", 64'({ready_o, error_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_select_o}), 64'd0);
    check("reset_wb_addr", 64'(wb_addr_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write with ack two cycles after stb.
    do_xfer(1'b0, 32'h40, 32'hDEADBEEF, 4'hF, 2, 32'h5555_AAAA, 1'b0, 1'b1, 1'b0);
    // Read acked in the first BUSY cycle.
    do_xfer(1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, 1'b1, 1'b0);
    // Back-to-back: second request issued in the RESP cycle.
    do_xfer(1'b0, 32'h48, 32'h1111_2222, 4'h3, 1, 32'h0, 1'b0, 1'b1, 1'b0);
    do_xfer(1'b1, 32'h4C, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);
    // Errors with and without ack.
    do_xfer(1'b0, 32'h50, 32'h0, 4'h0, 1, 32'h7777_7777, 1'b1, 1'b0, 1'b0);
    do_xfer(1'b0, 32'h54, 32'h0, 4'h0, 0, 32'h8888_8888, 1'b1, 1'b1, 1'b0);
    // Ack in the last permitted BUSY cycle is a normal completion.
    do_xfer(1'b0, 32'h58, 32'h0, 4'h0, TO_CYC - 1, 32'hABCD_0123, 1'b0, 1'b1, 1'b1);

    // Slave that never terminates.
    start_req(1'b0, 32'h60, 32'h0, 4'h0, t0);
`ifdef IOB2WB_TIMEOUT_EN
    begin
      rsp_t e;
      e.rdata = ERR_RD; e.err = 1'b1; e.cyc = t0 + TO_CYC + 1;
      rsp_q.push_back(e);
    end
    repeat (TO_CYC) begin
      @(posedge clk); #1;
    end
    check("timeout_cyc_drop", 64'(wb_cyc_o), 64'd0);
`else
    repeat (99) begin
      @(posedge clk); #1;
    end
    check("no_timeout_cyc_held", 64'(wb_cyc_o), 64'd1);
    reset_mid();
`endif

    // Reset while BUSY, then a read must complete normally.
    start_req(1'b0, 32'h80, 32'h0, 4'h0, t0);
    @(posedge clk); #1;
    reset_mid();
    do_xfer(1'b0, 32'h84, 32'h0, 4'h0, 1, 32'h0F0F_1234, 1'b0, 1'b1, 1'b0);

    // Randomised traffic.
    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit   err;
      bit   ack;
      int   delay;
      s     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      err   = ($urandom_range(0, 7) == 0);
      ack   = err ? 1'($urandom_range(0, 1)) : 1'b1;
      delay = int'($urandom_range(0, 4));
      do_xfer(b2b, {$urandom} & 32'hFFFF_FFFC, $urandom, s, delay, $urandom,
              err, ack, ($urandom_range(0, 4) == 0));
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b && ($urandom_range(0, 2) == 0)) idle_noise();
    end

    repeat (4) @(posedge clk);
    #1;
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("req_q_empty", 64'(req_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_iob_iob2wishbone
